// File: rtl/network_interface_pkg.sv
// Shared NoC definitions for the local network interface: default flit geometry,
// flit field offsets and the ejection-handshake state encoding.
package network_interface_pkg;

    localparam int LL_DEF = 16;
    localparam int MM_DEF = 2;

    // Flit layout for the default geometry: {dest X, dest Y, payload}
    localparam int DX_HI = LL_DEF - 1;
    localparam int DX_LO = LL_DEF - MM_DEF;
    localparam int DY_HI = LL_DEF - MM_DEF - 1;
    localparam int DY_LO = LL_DEF - 2 * MM_DEF;
    localparam int PL_HI = LL_DEF - 2 * MM_DEF - 1;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_ACK  = 1'b1
    } rx_state_t;

endpackage

// File: rtl/network_interface_if.sv
// Core-side and router-side handshake bundle of the local network interface.
// The slave modport is the network interface's own view.
interface network_interface_if #(
    parameter int LL = 16,
    parameter int MM = 2
);
    logic                 tx_valid;
    logic                 tx_ready;
    logic [MM-1:0]        tx_dx;
    logic [MM-1:0]        tx_dy;
    logic [LL-2*MM-1:0]   tx_payload;
    logic                 rx_valid;
    logic                 rx_ready;
    logic [LL-1:0]        rx_flit;
    logic                 rx_misroute;
    logic [LL-1:0]        inj_flit;
    logic                 inj_en;
    logic                 inj_full;
    logic [LL-1:0]        ej_flit;
    logic                 ej_req;
    logic                 ej_ans;
    logic                 ej_s;

    modport slave (
        input  tx_valid, tx_dx, tx_dy, tx_payload, rx_ready, inj_full, ej_flit, ej_req,
        output tx_ready, rx_valid, rx_flit, rx_misroute, inj_flit, inj_en, ej_ans, ej_s
    );

    modport master (
        output tx_valid, tx_dx, tx_dy, tx_payload, rx_ready, inj_full, ej_flit, ej_req,
        input  tx_ready, rx_valid, rx_flit, rx_misroute, inj_flit, inj_en, ej_ans, ej_s
    );
endinterface

// File: rtl/network_interface_fifo.sv
// Show-ahead synchronous FIFO; full/empty come from wrap-bit pointers only.
module noc_fifo #(
    parameter int W = 16,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = (D > 1) ? $clog2(D) : 1;

    logic [W-1:0] mem_r [D];
    logic [AW:0]  wr_ptr_r;
    logic [AW:0]  rd_ptr_r;
    logic         do_push_s;
    logic         do_pop_s;

    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign dout      = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; a push against a full FIFO is dropped even if a pop frees a slot
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/network_interface.sv
// Local-port network interface: packs core payloads into single-flit packets for
// the router and receives ejected flits over a four-phase req/ans handshake.
module network_interface
    import network_interface_pkg::*;
#(
    parameter int LL  = 16,
    parameter int MM  = 2,
    parameter int TXD = 4,
    parameter int RXD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [MM-1:0]     X,
    input  logic [MM-1:0]     Y,
    network_interface_if.slave bus,
    output logic [7:0]        tx_cnt,
    output logic [7:0]        rx_cnt
);
    logic [LL-1:0]     tx_din_s;
    logic [LL-1:0]     tx_head_s;
    logic              tx_full_s;
    logic              tx_empty_s;
    logic              tx_push_s;
    logic              inj_en_s;
    logic              ready_en_r;

    logic [LL-1:0]     rx_head_s;
    logic              rx_full_s;
    logic              rx_empty_s;
    logic              rx_push_s;
    logic              rx_pop_s;
    logic              ej_ans_s;
    logic              ej_s_r;
    logic              misroute_r;
    logic [2*MM-1:0]   dest_s;
    rx_state_t         state_r;
    rx_state_t         state_nx_s;

    logic [7:0]        tx_cnt_r;
    logic [7:0]        rx_cnt_r;

    // ---------------- TX path ----------------
    assign tx_din_s  = {bus.tx_dx, bus.tx_dy, bus.tx_payload};
    assign tx_push_s = bus.tx_valid & bus.tx_ready;
    assign inj_en_s  = ~tx_empty_s & ~bus.inj_full;

    noc_fifo #(.W(LL), .D(TXD)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push_s),
        .pop   (inj_en_s),
        .din   (tx_din_s),
        .dout  (tx_head_s),
        .full  (tx_full_s),
        .empty (tx_empty_s)
    );

    // ready_en_r holds tx_ready low while reset is applied
    assign bus.tx_ready = ready_en_r & ~tx_full_s;
    assign bus.inj_en   = inj_en_s;
    assign bus.inj_flit = tx_empty_s ? {LL{1'b0}} : tx_head_s;

    // ---------------- RX path ----------------
    assign rx_pop_s = ~rx_empty_s & bus.rx_ready;
    assign dest_s   = bus.ej_flit[LL-1:LL-2*MM];

    noc_fifo #(.W(LL), .D(RXD)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push_s),
        .pop   (rx_pop_s),
        .din   (bus.ej_flit),
        .dout  (rx_head_s),
        .full  (rx_full_s),
        .empty (rx_empty_s)
    );

    // Handshake state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= R_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Handshake next state: one push per req pulse, release waits for req low
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            R_IDLE: begin
                if (bus.ej_req && !rx_full_s) begin
                    state_nx_s = R_ACK;
                end else begin
                    state_nx_s = R_IDLE;
                end
            end
            R_ACK: begin
                if (!bus.ej_req) begin
                    state_nx_s = R_IDLE;
                end else begin
                    state_nx_s = R_ACK;
                end
            end
            default: state_nx_s = R_IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        rx_push_s = 1'b0;
        ej_ans_s  = 1'b0;
        case (state_r)
            R_IDLE:  rx_push_s = bus.ej_req & ~rx_full_s;
            R_ACK:   ej_ans_s  = 1'b1;
            default: begin
                rx_push_s = 1'b0;
                ej_ans_s  = 1'b0;
            end
        endcase
    end

    assign bus.ej_ans      = ej_ans_s;
    assign bus.ej_s        = ej_s_r;
    assign bus.rx_valid    = ~rx_empty_s;
    assign bus.rx_flit     = rx_empty_s ? {LL{1'b0}} : rx_head_s;
    assign bus.rx_misroute = misroute_r;

    // Status flags and flit counters
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_en_r <= 1'b0;
            ej_s_r     <= 1'b0;
            misroute_r <= 1'b0;
            tx_cnt_r   <= 8'd0;
            rx_cnt_r   <= 8'd0;
        end else begin
            ready_en_r <= 1'b1;
            ej_s_r     <= ~rx_full_s & (state_r == R_IDLE);
            if (rx_push_s && (dest_s != {X, Y})) begin
                misroute_r <= 1'b1;
            end
            if (inj_en_s) begin
                tx_cnt_r <= tx_cnt_r + 8'd1;
            end
            if (rx_push_s) begin
                rx_cnt_r <= rx_cnt_r + 8'd1;
            end
        end
    end

    assign tx_cnt = tx_cnt_r;
    assign rx_cnt = rx_cnt_r;

endmodule
